// File: rtl/babbage_stream.sv
// babbage_stream
//   Evaluates p(k) = sum_{i=0..DEG} c_i * k^i for k = 0..n using Babbage's
//   method of finite differences. The first DEG+1 points are computed by
//   Horner's rule. The table is then turned into forward differences.
//   Every further point costs one parallel add sweep over the table.
//
//   Parameters
//     DEG    polynomial degree (1..7)
//     CW     signed coefficient width
//     NW     unsigned evaluation-index width
//     W      signed result / datapath width (W >= CW)
//     STREAM 1: emit u(0)..u(n); 0: emit only u(n)
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     start      request, sampled only while ready=1
//     coef       packed signed coefficients, slice k is the n^k term
//     n          last index evaluated
//     ready      idle and accepting start
//     out_data   signed u(k)
//     out_valid  out_data is valid
//     out_ready  consumer accepts out_data
//     out_last   out_data is u(n)
//     done_tick  one-cycle pulse after the final handshake
//     ovf        sticky arithmetic overflow
//
//   Build option
//     BABBAGE_OVF_EN  when defined, ovf flags any EVAL/DIFF/STEP result that
//                     does not fit in W bits. Otherwise ovf is tied to 0 and
//                     results wrap silently.
module babbage_stream #(
  parameter int DEG    = 5,
  parameter int CW     = 16,
  parameter int NW     = 7,
  parameter int W      = 32,
  parameter int STREAM = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [(DEG+1)*CW-1:0] coef,
  input  logic [NW-1:0]         n,
  output logic                  ready,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done_tick,
  output logic                  ovf
);

  localparam int              CNTW  = $clog2(DEG + 1);
  localparam logic [CNTW-1:0] DEG_C = CNTW'(DEG);
  localparam logic [CNTW-1:0] ONE_C = CNTW'(1);
  localparam logic [NW-1:0]   K_ONE = NW'(1);

  typedef enum logic [2:0] {IDLE, EVAL, DIFF, STEP, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] coef_q [0:DEG];
  logic signed [W-1:0] t_q    [0:DEG];
  logic signed [W-1:0] acc_q;
  logic [NW-1:0]       n_q, k_q;
  logic [CNTW-1:0]     pt_q;    // Horner: point being evaluated
  logic [CNTW-1:0]     ph_q;    // Horner: 0 = load, 1..DEG = multiply-add
  logic [CNTW-1:0]     pass_q;  // difference pass 1..DEG
  logic signed [W-1:0] out_data_q;
  logic                out_valid_q, out_last_q;

  // Horner multiply-add: acc * x + c, with x = current point.
  logic signed [W-1:0] x_w, c_sel, mac_prod, mac_sum;

  assign x_w   = W'(pt_q);
  assign c_sel = coef_q[DEG_C - ph_q];

`ifdef BABBAGE_OVF_EN
  logic signed [2*W-1:0] prod_full;
  assign prod_full = $signed({{W{acc_q[W-1]}}, acc_q}) * $signed({{W{1'b0}}, x_w});
  assign mac_prod  = prod_full[W-1:0];
`else
  assign mac_prod  = acc_q * x_w;
`endif
  assign mac_sum = mac_prod + c_sel;

  // Output handshake. An output slot opens when the register is empty or is
  // being consumed, unless the word being consumed is the last one.
  logic hs_last, adv, step_en, load_en, eval_end, diff_end;

  assign hs_last  = (state_q == STEP) && out_valid_q && out_ready && out_last_q;
  assign adv      = (state_q == STEP) && (!out_valid_q || out_ready) && !hs_last;
  assign step_en  = adv && (k_q != n_q);
  assign load_en  = adv && ((STREAM != 0) || (k_q == n_q));
  assign eval_end = (state_q == EVAL) && (ph_q == DEG_C) && (pt_q == DEG_C);
  assign diff_end = (state_q == DIFF) && (pass_q == DEG_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = EVAL;
      EVAL:    if (eval_end) state_d = DIFF;
      DIFF:    if (diff_end) state_d = STEP;
      STEP:    if (hs_last)  state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the coefficient latch and the t table are register arrays with
      // an asynchronous clear, so they must stay flops (never inferred RAM).
      for (int i = 0; i <= DEG; i++) begin
        coef_q[i] <= '0;
        t_q[i]    <= '0;
      end
      acc_q       <= '0;
      n_q         <= '0;
      k_q         <= '0;
      pt_q        <= '0;
      ph_q        <= '0;
      pass_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i <= DEG; i++)
              coef_q[i] <= W'($signed(coef[i*CW +: CW]));
            n_q    <= n;
            k_q    <= '0;
            pt_q   <= '0;
            ph_q   <= '0;
            pass_q <= ONE_C;
          end
        end

        EVAL: begin
          if (ph_q == '0) begin
            acc_q <= coef_q[DEG];
            ph_q  <= ONE_C;
          end else begin
            acc_q <= mac_sum;
            if (ph_q == DEG_C) begin
              t_q[pt_q] <= mac_sum;
              ph_q      <= '0;
              pt_q      <= pt_q + ONE_C;
            end else begin
              ph_q <= ph_q + ONE_C;
            end
          end
        end

        DIFF: begin
          // NOTE: non-blocking assignments make every t[j] in the loop read
          // the pre-pass value of t[j-1], giving a true parallel update.
          for (int j = 1; j <= DEG; j++)
            if (j >= int'(pass_q)) t_q[j] <= t_q[j] - t_q[j-1];
          if (pass_q != DEG_C) pass_q <= pass_q + ONE_C;
        end

        STEP: begin
          // Advance past k only while more points remain, so the table
          // never steps beyond u(n).
          if (step_en) begin
            for (int j = 0; j < DEG; j++)
              t_q[j] <= t_q[j] + t_q[j+1];
            k_q <= k_q + K_ONE;
          end
          if (load_en) begin
            out_data_q  <= t_q[0];
            out_valid_q <= 1'b1;
            out_last_q  <= (k_q == n_q);
          end else if (hs_last) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

`ifdef BABBAGE_OVF_EN
  logic ovf_q, ovf_set;

  function automatic logic add_ovf(input logic signed [W-1:0] a, b, r);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [W-1:0] a, b, r);
    return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  always_comb begin
    ovf_set = 1'b0;
    if ((state_q == EVAL) && (ph_q != '0)) begin
      if (prod_full[2*W-1:W-1] != {(W+1){prod_full[W-1]}}) ovf_set = 1'b1;
      if (add_ovf(mac_prod, c_sel, mac_sum))                ovf_set = 1'b1;
    end
    if (state_q == DIFF) begin
      for (int j = 1; j <= DEG; j++)
        if ((j >= int'(pass_q)) && sub_ovf(t_q[j], t_q[j-1], t_q[j] - t_q[j-1]))
          ovf_set = 1'b1;
    end
    if (step_en) begin
      for (int j = 0; j < DEG; j++)
        if (add_ovf(t_q[j], t_q[j+1], t_q[j] + t_q[j+1])) ovf_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        ovf_q <= 1'b0;
    else if ((state_q == IDLE) && start) ovf_q <= 1'b0;
    else if (ovf_set)                  ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/babbage_stream.md
BABBAGE_STREAM -- requirements
Module: babbage_stream

Interface
REQ-001 SHALL have parameter DEG, default 5, meaning polynomial degree (1..7).
REQ-002 SHALL have parameter CW, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter NW, default 7, meaning unsigned evaluation-index width.
REQ-004 SHALL have parameter W, default 32, meaning signed result and internal datapath width.
REQ-005 SHALL have parameter STREAM, default 1, meaning 1 = emit u(0)..u(n) and 0 = emit only u(n).
REQ-006 SHALL have port clk  input  1  meaning the only clock; all state changes on the rising edge.
REQ-007 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  meaning a request sampled only while ready=1.
REQ-009 SHALL have port coef  input  (DEG+1)*CW  meaning packed signed coefficients, slice k is the n^k coefficient.
REQ-010 SHALL have port n  input  NW  meaning the last index evaluated.
REQ-011 SHALL have port ready  output  1  meaning the block is idle and will accept start.
REQ-012 SHALL have port out_data  output  W  meaning signed u(k).
REQ-013 SHALL have port out_valid  output  1  meaning out_data is valid.
REQ-014 SHALL have port out_ready  input  1  meaning the consumer accepts out_data.
REQ-015 SHALL have port out_last  output  1  meaning out_data is u(n).
REQ-016 SHALL have port done_tick  output  1  meaning a one-cycle pulse after the final handshake.
REQ-017 SHALL have port ovf  output  1  meaning sticky arithmetic overflow.

Function
REQ-018 SHALL use states IDLE, EVAL, DIFF, STEP and DONE.
REQ-019 SHALL, in IDLE with start=1, latch coef and n, clear ovf, and enter EVAL; start is ignored in all other states.
REQ-020 SHALL, in EVAL, compute u(0)..u(DEG) by Horner in table t[0..DEG]: one load cycle plus DEG multiply-add cycles per point, (DEG+1)^2 cycles in total.
REQ-021 SHALL, in DIFF, run DEG one-cycle passes; pass p updates t[j] <- t[j]-t[j-1] for j=DEG..p in parallel using old values, leaving t[j] = j-th forward difference at k=0.
REQ-022 SHALL, in STEP, present out_data=t[0] with index counter k starting at 0.
REQ-023 SHALL, on each step, update t[j] <- t[j]+t[j+1] for j<DEG in parallel using old values, and increment k.
REQ-024 SHALL, with STREAM=1, assert out_valid for every k and step only on out_valid&&out_ready.
REQ-025 SHALL, with STREAM=0, step internally with out_valid=0 while k<n, then assert out_valid with t[0]=u(n).
REQ-026 SHALL assert out_last together with out_valid when k==n.
REQ-027 SHALL hold out_data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL assert out_valid exactly (DEG+1)^2+DEG+1 cycles after the start-sampling edge when out_ready is held at 1.
REQ-029 SHALL, on the handshake with out_last=1, go to DONE, pulse done_tick for 1 cycle, then return to IDLE.
REQ-030 SHALL, for n=0, emit a single word u(0) with out_last=1.
REQ-031 SHALL do all arithmetic in W-bit two's complement, with coefficients sign-extended and n zero-extended.
REQ-032 SHALL assert ready=1 only in IDLE.

Reset
REQ-033 SHALL, with reset=0, immediately force IDLE, ready=1, out_data=0, out_valid=0, out_last=0, done_tick=0, ovf=0, t[]=0 and k=0, including mid-EVAL and mid-STEP.
REQ-034 SHALL resume operation on the first rising clk edge after reset returns to 1.

Configuration
REQ-035 SHALL, with macro BABBAGE_OVF_EN defined, set ovf when any EVAL, DIFF or STEP add/multiply result is not representable in W bits; ovf stays set until the next accepted start or reset.
REQ-036 SHALL, without BABBAGE_OVF_EN defined, tie ovf to 0, wrap results silently, and contain no overflow logic.

Verification (DEG=5, CW=16, NW=7, W=32)
REQ-037 SHALL cover: coef={c0=7, others 0}, n=3, STREAM=1 -> outputs 7,7,7,7; out_last on the 4th word; done_tick one cycle later.
REQ-038 SHALL cover: c5=1, others 0, n=4 -> outputs 0,1,32,243,1024; first out_valid exactly 42 cycles after start is sampled.
REQ-039 SHALL cover: c5=-1, c4=2, c3=-7, c2=5, c1=-31, c0=-511, n=100, STREAM=0 -> a single word equal to the multiply-reference value, with out_last=1.
REQ-040 SHALL cover: REQ-038 stimulus with out_ready=0 for 3 cycles at word 32 -> 32 held stable, and no word lost or duplicated.
REQ-041 SHALL cover: c5=32767, n=127, BABBAGE_OVF_EN defined -> ovf=1 by done_tick; same stimulus without the macro -> ovf=0.
REQ-042 SHALL cover: reset=0 asserted mid-STEP (asynchronously, between clock edges) -> outputs take reset values before the next edge, then a fresh start yields correct results.
